commutation_sequencer: RTL
==========================

COMMUTATION_SEQUENCER -- requirements
Module: commutation_sequencer

Interface
REQ-001 Parameter DEAD_CYCLES, default 8, SHALL set the dead-time length in clk cycles; legal range 1..255.
REQ-002 clk  input  1  SHALL be the single clock; all logic is rising-edge clk.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 enable  input  1  SHALL be the run request; level-sensitive.
REQ-005 dir  input  1  SHALL select direction: 1 = forward (state +1), 0 = reverse (state -1).
REQ-006 step_tick  input  1  SHALL be a one-cycle commutation-advance request.
REQ-007 duty  input  1  SHALL be the PWM gate applied to the active high side.
REQ-008 fault  input  1  SHALL be an external overcurrent/fault level.
REQ-009 HIN_R, HIN_S, HIN_T  output  1 each  SHALL be the active-high high-side gate drives.
REQ-010 LIN_R_n, LIN_S_n, LIN_T_n  output  1 each  SHALL be the active-low low-side gate drives.
REQ-011 rotate_state  output  3  SHALL be the current commutation step, 0..5.
REQ-012 in_dead  output  1  SHALL be high while the sequencer is in DEAD.
REQ-013 step_drop  output  1  SHALL pulse for one cycle when a step_tick is discarded.
REQ-014 fault_latched  output  1  SHALL be high while in FAULT.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DEAD and FAULT.
REQ-016 In IDLE, all gates SHALL be off (HIN=0, LIN_n=1); enable=1 with fault=0 SHALL move to RUN on the next cycle.
REQ-017 RUN SHALL drive gates from rotate_state using this table (high phase / low phase): 0 R/S, 1 R/T, 2 S/T, 3 S/R, 4 T/R, 5 T/S.
REQ-018 In RUN, the high-phase HIN SHALL equal the registered duty (1-cycle latency); the low-phase LIN_n SHALL be held at 0; the third phase SHALL be off.
REQ-019 step_tick in RUN SHALL enter DEAD and turn all gates off in the same output update.
REQ-020 DEAD SHALL last exactly DEAD_CYCLES cycles; on exit, rotate_state SHALL update by ±1 mod 6 per dir (as sampled at the step_tick), and the FSM SHALL return to RUN.
REQ-021 Wrap-around: forward 5->0; reverse 0->5.
REQ-022 step_tick in DEAD or IDLE SHALL be discarded with a step_drop pulse; it SHALL NOT be queued.
REQ-023 enable=0 in RUN or DEAD SHALL go to IDLE next cycle, with all gates off and rotate_state unchanged; an aborted DEAD SHALL NOT advance rotate_state.
REQ-024 fault=1 in any state SHALL go to FAULT next cycle, with all gates off; fault SHALL take priority over step_tick and enable.
REQ-025 FAULT SHALL be sticky; it SHALL exit to IDLE only when fault=0 and enable=0 in the same cycle.
REQ-026 Gate outputs SHALL be registered; no output SHALL ever have HIN_x=1 and LIN_x_n=0 simultaneously.
REQ-027 If rotate_state ever holds 6 or 7, it SHALL be forced to 0 on the next cycle, with gates off for that cycle.

Reset
REQ-028 rst SHALL set: FSM=IDLE, rotate_state=0, HIN_*=0, LIN_*_n=1, in_dead=0, step_drop=0, fault_latched=0, dead counter=0.
REQ-029 rst asserted mid-DEAD or in FAULT SHALL take the reset values on the next edge, overriding all other inputs.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the 6-entry commutation table constant (high/low phase per step) and the phase index type.
REQ-031 A single sub-module, dead_timer (load, count down, done pulse; width sized by DEAD_CYCLES), SHALL be instantiated once.

Verification
REQ-032 Scenario: rst, then enable=1, duty=1, state 0 -> HIN_R=1, LIN_S_n=0, all others off, within 2 cycles.
REQ-033 Scenario: step_tick with dir=1 at state 5 and DEAD_CYCLES=8 -> all gates off for exactly 8 cycles, then rotate_state=0 with R/S driven.
REQ-034 Scenario: dir=0 at state 0 with a step -> rotate_state=5 after dead time; HIN_T=1, LIN_S_n=0.
REQ-035 Scenario: second step_tick 3 cycles into DEAD -> one step_drop pulse, and only one advance occurs.
REQ-036 Scenario: fault=1 in the same cycle as step_tick -> FAULT, all gates off, rotate_state unchanged; fault=0 with enable=1 keeps FAULT; enable=0 then returns to IDLE.
REQ-037 Scenario: duty toggling every cycle for 100 cycles in RUN -> HIN follows duty delayed by 1 cycle; a shoot-through assertion never fires.

Source files
------------

// File: rtl/commutation_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : commutation_sequencer_pkg
// Description : Shared types and constants for the six-step commutation
//               sequencer. It holds the FSM state enum, the phase index type,
//               the 6-entry high/low phase commutation table and a helper
//               that advances a step index by one, wrapping modulo 6.
// Ports       : (package - none)
// Revision    : 1.0 - initial release
// ============================================================================
package commutation_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DEAD  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    // Phase index; its value is also the bit position in the 3-bit gate
    // vectors ({T, S, R}).
    typedef logic [1:0] phase_t;

    localparam phase_t c_ph_r = 2'd0;
    localparam phase_t c_ph_s = 2'd1;
    localparam phase_t c_ph_t = 2'd2;

    typedef struct packed {
        phase_t hi;   // phase whose high-side switch carries PWM
        phase_t lo;   // phase whose low-side switch is held on
    } comm_entry_t;

    // Step -> (high phase, low phase).
    localparam comm_entry_t [0:5] c_comm_table = '{
        '{hi: c_ph_r, lo: c_ph_s},   // 0: R/S
        '{hi: c_ph_r, lo: c_ph_t},   // 1: R/T
        '{hi: c_ph_s, lo: c_ph_t},   // 2: S/T
        '{hi: c_ph_s, lo: c_ph_r},   // 3: S/R
        '{hi: c_ph_t, lo: c_ph_r},   // 4: T/R
        '{hi: c_ph_t, lo: c_ph_s}    // 5: T/S
    };

    // Next step in the requested direction; forward wraps 5->0 and reverse
    // wraps 0->5. The caller must pass a step in the range 0..5.
    function automatic logic [2:0] step_advance(input logic [2:0] step,
                                                input logic       fwd);
        if (fwd) begin
            return (step == 3'd5) ? 3'd0 : step + 3'd1;
        end else begin
            return (step == 3'd0) ? 3'd5 : step - 3'd1;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/commutation_sequencer_dead_timer.sv
`default_nettype none
// ============================================================================
// Module      : dead_timer
// Description : Dead-time down counter. i_load loads DEAD_CYCLES; the counter
//               then decrements once per clock down to zero. o_done is high
//               in the last dead cycle, i.e. while the count equals 1, so the
//               edge on which o_done is seen ends a DEAD_CYCLES-long interval.
//               i_clr abandons an interval in progress.
// Ports       : clk     - clock
//               rst     - synchronous active-high reset
//               i_load  - start a new dead interval (wins over i_clr)
//               i_clr   - abandon the current interval
//               o_done  - the current cycle is the last dead cycle
// Revision    : 1.0 - initial release
// ============================================================================
module dead_timer #(
    parameter int unsigned DEAD_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_clr,
    output logic o_done
);

    localparam int unsigned             c_cnt_w    = $clog2(DEAD_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]      c_load_val = c_cnt_w'(DEAD_CYCLES);
    localparam logic [c_cnt_w-1:0]      c_one      = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_load) begin
            w_cnt_d = c_load_val;
        end else if (i_clr) begin
            w_cnt_d = '0;
        end else if (r_cnt != '0) begin
            w_cnt_d = r_cnt - c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    assign o_done = (r_cnt == c_one);

endmodule
`default_nettype wire

// File: rtl/commutation_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : commutation_sequencer
// Description : Six-step BLDC commutation sequencer with dead time between
//               steps, fault latching and registered, shoot-through-free gate
//               outputs.
// Ports       : clk                       - clock (rising edge)
//               rst                       - synchronous active-high reset
//               enable                    - run request (level)
//               dir                       - 1 = forward (+1), 0 = reverse (-1)
//               step_tick                 - one-cycle commutation advance request
//               duty                      - PWM gate for the active high side
//               fault                     - external fault level
//               HIN_R/HIN_S/HIN_T         - high-side drives, active high
//               LIN_R_n/LIN_S_n/LIN_T_n   - low-side drives, active low
//               rotate_state              - current commutation step 0..5
//               in_dead                   - sequencer is in dead time
//               step_drop                 - a step_tick was discarded
//               fault_latched             - sequencer is in FAULT
// Revision    : 1.0 - initial release
// ============================================================================
module commutation_sequencer #(
    parameter int unsigned DEAD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       dir,
    input  logic       step_tick,
    input  logic       duty,
    input  logic       fault,
    output logic       HIN_R,
    output logic       HIN_S,
    output logic       HIN_T,
    output logic       LIN_R_n,
    output logic       LIN_S_n,
    output logic       LIN_T_n,
    output logic [2:0] rotate_state,
    output logic       in_dead,
    output logic       step_drop,
    output logic       fault_latched
);

    import commutation_sequencer_pkg::*;

    state_e      r_state;
    logic [2:0]  r_rot;
    logic        r_dir;
    logic [2:0]  r_hin;       // {T, S, R}
    logic [2:0]  r_lin_n;     // {T, S, R}
    logic        r_in_dead;
    logic        r_drop;
    logic        r_fault_latched;

    state_e      w_state_d;
    logic [2:0]  w_rot_d;
    logic        w_dir_d;
    logic [2:0]  w_hin_d;
    logic [2:0]  w_lin_n_d;
    logic        w_drop_d;
    logic        w_rot_bad;
    logic        w_timer_load;
    logic        w_timer_clr;
    logic        w_timer_done;
    comm_entry_t w_entry;

    dead_timer #(
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_dead_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_timer_load),
        .i_clr  (w_timer_clr),
        .o_done (w_timer_done)
    );

    always_comb begin
        w_state_d    = r_state;
        w_rot_d      = r_rot;
        w_dir_d      = r_dir;
        w_drop_d     = 1'b0;
        w_timer_load = 1'b0;
        w_rot_bad    = (r_rot > 3'd5);

        case (r_state)
            ST_IDLE: begin
                w_drop_d = step_tick;
                if (enable) begin
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    w_state_d = ST_IDLE;
                end else if (step_tick) begin
                    w_state_d    = ST_DEAD;
                    w_timer_load = 1'b1;
                    w_dir_d      = dir;   // direction is frozen at the tick
                end
            end
            ST_DEAD: begin
                w_drop_d = step_tick;
                if (!enable) begin
                    // Abort: leave the step where it was.
                    w_state_d = ST_IDLE;
                end else if (w_timer_done) begin
                    w_state_d = ST_RUN;
                    w_rot_d   = step_advance(r_rot, r_dir);
                end
            end
            ST_FAULT: begin
                if (!fault && !enable) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Fault outranks every other request, including a pending step.
        if (fault) begin
            w_state_d    = ST_FAULT;
            w_rot_d      = r_rot;
            w_drop_d     = 1'b0;
            w_timer_load = 1'b0;
        end

        if (w_rot_bad) begin
            w_rot_d = 3'd0;
        end

        // Gates are computed from the next state so they change on the same
        // edge as the state; duty is sampled here, giving one cycle latency.
        w_hin_d   = 3'b000;
        w_lin_n_d = 3'b111;
        w_entry   = c_comm_table[w_rot_d];
        if ((w_state_d == ST_RUN) && !w_rot_bad) begin
            w_hin_d[w_entry.hi]   = duty;
            w_lin_n_d[w_entry.lo] = 1'b0;
        end

        w_timer_clr = (w_state_d != ST_DEAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_rot           <= 3'd0;
            r_dir           <= 1'b0;
            r_hin           <= 3'b000;
            r_lin_n         <= 3'b111;
            r_in_dead       <= 1'b0;
            r_drop          <= 1'b0;
            r_fault_latched <= 1'b0;
        end else begin
            r_state         <= w_state_d;
            r_rot           <= w_rot_d;
            r_dir           <= w_dir_d;
            r_hin           <= w_hin_d;
            r_lin_n         <= w_lin_n_d;
            r_in_dead       <= (w_state_d == ST_DEAD);
            r_drop          <= w_drop_d;
            r_fault_latched <= (w_state_d == ST_FAULT);
        end
    end

    assign HIN_R         = r_hin[0];
    assign HIN_S         = r_hin[1];
    assign HIN_T         = r_hin[2];
    assign LIN_R_n       = r_lin_n[0];
    assign LIN_S_n       = r_lin_n[1];
    assign LIN_T_n       = r_lin_n[2];
    assign rotate_state  = r_rot;
    assign in_dead       = r_in_dead;
    assign step_drop     = r_drop;
    assign fault_latched = r_fault_latched;

endmodule
`default_nettype wire
